tog_event_rx: RTL and testbench
===============================

# tog_event_rx

Two-phase (toggle) event receiver: the decoding end of the team's T-flip-flop toggle signalling, where an upstream block flips one line once per event. It detects every transition on `tog_in`, emits a one-cycle `pulse` per transition, and queues the events in a saturating pending counter. Events are offered downstream through a valid/ready handshake. Every consumed event is acknowledged back upstream by flipping `ack_tog`. It sits between a toggle-based event source and a synchronous consumer.

## Interface
- `CNT_W`, default 4 – width of the pending-event counter; maximum queued events = 2^CNT_W − 1.
- `clk`  in  1  – rising-edge clock, sole clock of the block.
- `rstn`  in  1  – synchronous, active-low reset, sampled on `clk` rising edge.
- `tog_in`  in  1  – event line; each level change (0→1 or 1→0) is one event.
- `ready`  in  1  – downstream can accept one event this cycle.
- `valid`  out  1  – at least one event pending.
- `pulse`  out  1  – registered, one-cycle strobe per detected transition.
- `pending`  out  CNT_W  – current number of queued events.
- `ack_tog`  out  1  – flips once per consumed event (valid && ready).
- `ovf`  out  1  – sticky flag: an event was lost because the counter was full.

## Operation
- Input path is a shift chain ending in `last`.
  - With `SYNC_EN`: `tog_in` → `s1` → `s2` → `last`. Detected edge: `det = s2 ^ last`.
  - Without `SYNC_EN`: `tog_in` → `s2` → `last`. Detected edge: `det = s2 ^ last`.
- `pulse <= det` every cycle.
- Consume: `take = valid && ready`. The combinational `valid = (pending != 0)`.
- Counter update, per cycle:
  - `det` && !`take`: `pending` +1 if below max. At max, `pending` holds and `ovf` <= 1.
  - !`det` && `take`: `pending` −1.
  - `det` && `take`: `pending` unchanged. No overflow is possible in this case, even at max.
  - neither: hold.
- `ack_tog <= ack_tog ^ take`.
- `ovf` clears only on reset.
- Arithmetic: `pending` is unsigned CNT_W bits. It never wraps in either direction. Decrement cannot occur at 0 because `valid` = 0 there.

## Timing
- Reset: while `rstn` = 0 at a rising edge, all of the following become 0: `s1`, `s2`, `last`, `pulse`, `pending`, `ack_tog`, `ovf`. Consequently `valid` = 0.
- Reset mid-operation: queued events are discarded and `ack_tog` returns to 0. The upstream source must also be reset in the same cycle.
- If `tog_in` = 1 when reset releases, one event is detected. This is intentional: the line left its reset level.
- Latency, with `tog_in` changing before rising edge E0 (the first edge that samples the new level):
  - `SYNC_EN` defined: `det` is high after E1; `pulse` and the `pending` increment appear after E2.
  - `SYNC_EN` undefined: `det` is high after E0; `pulse` and the increment appear after E1.
- Throughput: one event per cycle, i.e. `tog_in` may toggle every cycle. Each toggle produces one `pulse` cycle, so back-to-back toggles give `pulse` high on consecutive cycles.
- Handshake:
  - `valid` never depends on `ready`.
  - A transfer occurs on a rising edge where `valid` && `ready`.
  - `ack_tog` flips on that same edge.
  - `ready` may be held high continuously.

## Configuration
- `TOG_RX_SYNC_EN`:
  - Defined: adds stage `s1`, a two-flop synchronizer ahead of edge detection. This makes `tog_in` safe to drive from an unrelated clock domain and adds one cycle of latency.
  - Undefined: `tog_in` must be synchronous to `clk`; latency is one cycle lower.
- Counter, handshake, overflow and reset behaviour are identical in both builds.

## Test plan
- Reset with `tog_in` = 0, then hold 5 cycles → `valid`, `pulse`, `pending`, `ack_tog`, `ovf` all 0.
- Single toggle 0→1 with `ready` = 0:
  - `pulse` high for exactly 1 cycle, 2 cycles after the sampling edge with SYNC_EN (1 cycle without).
  - `pending` = 1 and `valid` = 1.
  - Then assert `ready` for 1 cycle → `pending` = 0, `ack_tog` = 1.
- Toggle `tog_in` every cycle for 6 cycles with `ready` = 0 → 6 consecutive `pulse` cycles, `pending` = 6.
- Drain the 6 events with `ready` held high → `ack_tog` flips 6 times and ends at 0; `valid` drops after the 6th transfer.
- CNT_W = 4, `ready` = 0, 16 toggles:
  - `pending` saturates at 15 and `ovf` = 1.
  - One further toggle with `ready` = 1 at `pending` = 15 → `pending` stays 15.
  - `ovf` stays 1 until reset.
- Simultaneous `det` and `take` at `pending` = 3 → `pending` stays 3, `pulse` = 1, `ack_tog` flips.
- `rstn` = 0 for one cycle with `pending` = 5 → next cycle `pending` = 0, `ack_tog` = 0, `ovf` = 0.

Source files
------------

// File: rtl/tog_event_rx_if.sv
// Handshake bundle for the toggle event receiver.
// The master side is the event source and consumer. The slave side is the receiver.
interface tog_event_rx_if #(
   parameter int CNT_W = 4
);
   logic             tog_in;
   logic             ready;
   logic             valid;
   logic             pulse;
   logic [CNT_W-1:0] pending;
   logic             ack_tog;
   logic             ovf;

   modport master (
      output tog_in, ready,
      input  valid, pulse, pending, ack_tog, ovf
   );

   modport slave (
      input  tog_in, ready,
      output valid, pulse, pending, ack_tog, ovf
   );
endinterface

// File: rtl/tog_event_rx.sv
// Two-phase toggle event receiver: edge detect, saturating pending counter, valid/ready drain, toggle ack.
// Optional TOG_RX_SYNC_EN adds a synchronizer flop (s1) ahead of edge detection.
module tog_event_rx #(
   parameter int CNT_W = 4
) (
   input logic          clk,
   input logic          rstn,
   tog_event_rx_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef TOG_RX_SYNC_EN
   logic             s1;
`endif
   logic             s2;
   logic             last;
   logic             det;
   logic             take;
   logic             valid_int;
   logic             pulse_q;
   logic             ack_q;
   logic             ovf_q;
   logic [CNT_W-1:0] pending_q;

   // Increment saturates at CNT_MAX. A simultaneous event and consume cancel out.
   function automatic logic [CNT_W-1:0] next_count(
      input logic [CNT_W-1:0] cur,
      input logic             inc,
      input logic             dec
   );
      logic [CNT_W-1:0] res;
      res = cur;
      if (inc && !dec && (cur != CNT_MAX))
         res = cur + CNT_ONE;
      else if (dec && !inc)
         res = cur - CNT_ONE;
      return res;
   endfunction

   assign det       = s2 ^ last;
   assign valid_int = (pending_q != '0);
   assign take      = valid_int && bus.ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
`ifdef TOG_RX_SYNC_EN
         s1        <= 1'b0;
`endif
         s2        <= 1'b0;
         last      <= 1'b0;
         pulse_q   <= 1'b0;
         pending_q <= '0;
         ack_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         // input capture / edge-detect stage
`ifdef TOG_RX_SYNC_EN
         s1        <= bus.tog_in;
         s2        <= s1;
`else
         s2        <= bus.tog_in;
`endif
         last      <= s2;
         // event bookkeeping stage
         pulse_q   <= det;
         pending_q <= next_count(pending_q, det, take);
         ack_q     <= ack_q ^ take;
         if (det && !take && (pending_q == CNT_MAX))
            ovf_q <= 1'b1;
      end
   end

   assign bus.valid   = valid_int;
   assign bus.pulse   = pulse_q;
   assign bus.pending = pending_q;
   assign bus.ack_tog = ack_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_tog_event_rx.sv
// Directed bench for tog_event_rx: table of per-cycle vectors plus corner-case sequences.
// The table is written in terms of the level seen at the edge detector; synchronizer builds feed it one row early.
module tb_tog_event_rx;

`ifdef TOG_RX_SYNC_EN
   localparam int PULSE_EDGE = 2;
   localparam bit SYNC       = 1'b1;
`else
   localparam int PULSE_EDGE = 1;
   localparam bit SYNC       = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   total;
   int   bad;

   tog_event_rx_if #(.CNT_W(4)) bus ();

   tog_event_rx #(.CNT_W(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       tog;
      logic       rdy;
      logic       v;
      logic       p;
      logic [3:0] pend;
      logic       a;
      logic       o;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic tog, input logic rdy, input logic v, input logic p,
                      input logic [3:0] pend, input logic a, input logic o);
      vec_t r;
      r = '{tog: tog, rdy: rdy, v: v, p: p, pend: pend, a: a, o: o};
      tbl.push_back(r);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".valid"},   32'(bus.valid),   32'd0);
      check({name, ".pulse"},   32'(bus.pulse),   32'd0);
      check({name, ".pending"}, 32'(bus.pending), 32'd0);
      check({name, ".ack_tog"}, 32'(bus.ack_tog), 32'd0);
      check({name, ".ovf"},     32'(bus.ovf),     32'd0);
   endtask

   initial begin
      logic [7:0] act_v;
      logic [7:0] exp_v;
      int         first;
      int         npulse;
      total = 0;
      bad   = 0;

      // Columns: tog, ready, then expected valid, pulse, pending, ack_tog, ovf after the edge
      add(0,0, 0,0,0,0,0);
      add(1,0, 0,0,0,0,0);
      add(1,0, 1,1,1,0,0);
      add(1,0, 1,0,1,0,0);
      add(1,1, 0,0,0,1,0);
      add(0,0, 0,0,0,1,0);
      add(0,1, 1,1,1,1,0);
      add(0,1, 0,0,0,0,0);
      add(1,0, 0,0,0,0,0);
      add(0,0, 1,1,1,0,0);
      add(1,0, 1,1,2,0,0);
      add(0,0, 1,1,3,0,0);
      add(1,0, 1,1,4,0,0);
      add(0,0, 1,1,5,0,0);
      add(0,0, 1,1,6,0,0);
      add(0,0, 1,0,6,0,0);
      add(0,1, 1,0,5,1,0);
      add(0,1, 1,0,4,0,0);
      add(0,1, 1,0,3,1,0);
      add(0,1, 1,0,2,0,0);
      add(0,1, 1,0,1,1,0);
      add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      add(1,0, 0,0,0,0,0);
      add(0,0, 1,1,1,0,0);
      add(1,0, 1,1,2,0,0);
      add(1,0, 1,1,3,0,0);
      add(0,0, 1,0,3,0,0);
      add(0,1, 1,1,3,1,0);
      add(0,0, 1,0,3,1,0);

      // Reset with the line low, then five idle cycles
      rstn       = 1'b0;
      bus.tog_in = 1'b0;
      bus.ready  = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rstn = 1'b1;
      repeat (5) tick();
      check_all_zero("idle5");

      for (int i = 0; i < tbl.size(); i++) begin
         if (SYNC)
            bus.tog_in = (i + 1 < tbl.size()) ? tbl[i+1].tog : tbl[i].tog;
         else
            bus.tog_in = tbl[i].tog;
         bus.ready = tbl[i].rdy;
         tick();
         act_v = {bus.valid, bus.pulse, bus.pending, bus.ack_tog, bus.ovf};
         exp_v = {tbl[i].v, tbl[i].p, tbl[i].pend, tbl[i].a, tbl[i].o};
         check($sformatf("row%0d", i), 32'(act_v), 32'(exp_v));
      end

      // Line high across reset: exactly one event, at the documented latency
      bus.ready  = 1'b0;
      bus.tog_in = 1'b1;
      rstn       = 1'b0;
      tick();
      check_all_zero("reset_tog_high");
      rstn   = 1'b1;
      first  = -1;
      npulse = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.pulse) begin
            npulse++;
            if (first < 0) first = k;
         end
      end
      check("latency.first_pulse_edge", 32'(first), 32'(PULSE_EDGE));
      check("latency.pulse_count",      32'(npulse), 32'd1);
      check("latency.pending",          32'(bus.pending), 32'd1);
      check("latency.valid",            32'(bus.valid), 32'd1);

      // Saturation at 15 with overflow on the 16th event
      bus.tog_in = 1'b0;
      rstn       = 1'b0;
      tick();
      rstn = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 15; i++) begin
         bus.tog_in = ~bus.tog_in;
         tick();
      end
      repeat (4) tick();
      check("sat15.pending", 32'(bus.pending), 32'd15);
      check("sat15.ovf",     32'(bus.ovf),     32'd0);
      bus.tog_in = ~bus.tog_in;
      tick();
      repeat (4) tick();
      check("sat16.pending", 32'(bus.pending), 32'd15);
      check("sat16.ovf",     32'(bus.ovf),     32'd1);
      check("sat16.valid",   32'(bus.valid),   32'd1);

      // Event and consume on the same edge while full
      bus.tog_in = ~bus.tog_in;
      tick();
      repeat (PULSE_EDGE - 1) tick();
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      check("full_both.pending", 32'(bus.pending), 32'd15);
      check("full_both.pulse",   32'(bus.pulse),   32'd1);
      check("full_both.ack_tog", 32'(bus.ack_tog), 32'd1);
      repeat (3) tick();
      check("full_hold.pending", 32'(bus.pending), 32'd15);
      check("full_hold.ovf",     32'(bus.ovf),     32'd1);

      // Drain ten, then reset mid-operation with five queued
      bus.ready = 1'b1;
      repeat (10) tick();
      bus.ready = 1'b0;
      check("drain10.pending", 32'(bus.pending), 32'd5);
      check("drain10.ack_tog", 32'(bus.ack_tog), 32'd1);
      check("drain10.ovf",     32'(bus.ovf),     32'd1);
      rstn       = 1'b0;
      bus.tog_in = 1'b0;
      tick();
      check_all_zero("midreset");
      rstn = 1'b1;
      repeat (4) tick();
      check("after_midreset.pending", 32'(bus.pending), 32'd0);
      check("after_midreset.pulse",   32'(bus.pulse),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
